sisc_fetch_unit: RTL and testbench

//  - SISC instruction-fetch stage, directly upstream of the control FSM: holds PC and IR.
//  - Fetches from instruction memory over a req/ack handshake and applies the branch PC updates the FSM commands.
//  - Feeds the FSM its opcode and mm fields via ir.
//  - fetch_busy tells the FSM to hold in fetch until IR is valid.

---
 rtl/sisc_fetch_unit.sv | 127 ++++++++++++
 tb/tb_sisc_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_fetch_unit.sv
// SISC fetch stage: PC/IR registers, imem req/ack fetch, branch PC update.
// Define SISC_FETCH_TIMEOUT_EN to enable the imem_ack timeout and ERR state.
module sisc_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef SISC_FETCH_TIMEOUT_EN
  , parameter int TIMEOUT = 15
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  input  logic [15:0]        imm,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic               fetch_busy,
  output logic               fetch_err
);

`ifdef SISC_FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  typedef enum logic [0:0] {
    S_IDLE,
    S_WAIT
  } state_t;
`endif

  state_t state;

  logic [ADDR_W-1:0] imm_abs;
  logic [ADDR_W-1:0] imm_rel;
  logic [ADDR_W-1:0] pc_next;

  assign imm_abs = ADDR_W'(imm);
  assign imm_rel = ADDR_W'($signed(imm));

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    unique case (1'b1)
      !pc_sel:           pc_next = pc + ADDR_W'(1);
      pc_sel && br_sel:  pc_next = imm_abs;
      pc_sel && !br_sel: pc_next = pc + imm_rel;
    endcase
  end

  assign fetch_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      ir_valid  <= 1'b0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
`ifdef SISC_FETCH_TIMEOUT_EN
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
`endif
    end else begin
      ir_valid <= 1'b0;
      if (pc_rst)
        pc <= RESET_PC;
      else if (pc_write)
        pc <= pc_next;
      case (state)
        S_IDLE: begin
          if (ir_load) begin
            imem_addr <= pc;
            imem_req  <= 1'b1;
            state     <= S_WAIT;
`ifdef SISC_FETCH_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            imem_req <= 1'b0;
            state    <= S_IDLE;
          end
`ifdef SISC_FETCH_TIMEOUT_EN
          // Last allowed wait cycle: substitute a NOOP
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            ir        <= '0;
            ir_valid  <= 1'b1;
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
`ifdef SISC_FETCH_TIMEOUT_EN
        S_ERR: state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SISC_FETCH_TIMEOUT_EN
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_sisc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, pc_rst, pc_write, pc_sel, br_sel, ir_load;
  logic [15:0] imm;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, pc;
  logic [31:0] imem_rdata, ir;
  logic        ir_valid, fetch_busy, fetch_err;

  int checks = 0;
  int errors = 0;

  localparam int TMO = 15;

  sisc_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load), .imm(imm),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .ir(ir), .ir_valid(ir_valid),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a pending-fetch flag and a count of unanswered cycles
  int          m_pc, m_addr, m_waited;
  logic [31:0] m_ir;
  bit          m_req, m_busy, m_err, m_valid, m_in_err;

  task automatic model_step();
    int old, off;
    old = m_pc;
    off = (imm >= 16'h8000) ? int'(imm) - 65536 : int'(imm);
    if (rst) begin
      m_pc = 0; m_ir = 0; m_req = 0; m_busy = 0;
      m_err = 0; m_valid = 0; m_addr = 0; m_in_err = 0;
    end else begin
      m_valid = 0;
      if (pc_rst) m_pc = 0;
      else if (pc_write) begin
        if (!pc_sel) m_pc = (old + 1) % 65536;
        else if (br_sel) m_pc = int'(imm);
        else m_pc = (old + off + 65536) % 65536;
      end
      if (m_in_err) begin
        m_in_err = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (ir_load) begin
          m_addr = old; m_req = 1; m_busy = 1; m_waited = 0;
        end
      end else if (imem_ack) begin
        m_ir = imem_rdata; m_valid = 1; m_req = 0; m_busy = 0;
      end else begin
        m_waited++;
`ifdef SISC_FETCH_TIMEOUT_EN
        if (m_waited == TMO) begin
          m_ir = 0; m_valid = 1; m_err = 1; m_req = 0; m_in_err = 1;
        end
`endif
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0;
    ir_load = 0; imm = 0; imem_ack = 0; imem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (pc !== 16'h0 || ir !== 32'h0 || imem_req !== 1'b0 ||
        fetch_busy !== 1'b0 || fetch_err !== 1'b0 ||
        ir_valid !== 1'b0 || imem_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_state pc=%h ir=%h req=%b busy=%b err=%b vld=%b addr=%h expected all 0",
               pc, ir, imem_req, fetch_busy, fetch_err, ir_valid, imem_addr);
    end
    ir_load = 1;
    tick();
    ir_load = 0;
    tick();
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_wait req=%b expected 1", imem_req);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait req=%b busy=%b expected 0 0", imem_req, fetch_busy);
    end
    imem_ack = 1;
    imem_rdata = $urandom | 32'h1;
    tick();
    imem_ack = 0;
    checks++;
    if (ir !== 32'h0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_late_ack ir=%h vld=%b expected 0 0", ir, ir_valid);
    end
  endtask

  task automatic test_fetch();
    int busy_cnt, vld_cnt;
    idle_inputs();
    pc_rst = 1;
    tick();
    pc_rst = 0;
    pc_write = 1;
    repeat (5) tick();
    ir_load = 1;
    tick();
    ir_load = 0;
    pc_write = 0;
    checks++;
    if (imem_addr !== 16'd5 || pc !== 16'd6 || imem_req !== 1'b1) begin
      errors++;
      $display("FAIL fetch_issue addr=%h pc=%h req=%b expected 0005 0006 1",
               imem_addr, pc, imem_req);
    end
    busy_cnt = 0;
    vld_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (fetch_busy) busy_cnt++;
      if (ir_valid) vld_cnt++;
      imem_ack = (i == 3);
      imem_rdata = (i == 3) ? 32'h8123_0004 : $urandom;
      tick();
      imem_ack = 0;
      if (i == 3) begin
        checks++;
        if (ir !== 32'h8123_0004 || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
          errors++;
          $display("FAIL fetch_data ir=%h vld=%b req=%b expected 81230004 1 0",
                   ir, ir_valid, imem_req);
        end
      end
    end
    checks++;
    if (busy_cnt !== 4 || vld_cnt !== 1) begin
      errors++;
      $display("FAIL fetch_busy_len busy=%0d vld=%0d expected 4 1", busy_cnt, vld_cnt);
    end
  endtask

  task automatic test_branch();
    idle_inputs();
    pc_write = 1; pc_sel = 1; br_sel = 1; imm = 16'h0010;
    tick();
    br_sel = 0; imm = 16'hFFFE;
    tick();
    checks++;
    if (pc !== 16'h000E) begin
      errors++;
      $display("FAIL branch_rel pc=%h expected 000e", pc);
    end
    br_sel = 1; imm = 16'h0040;
    tick();
    checks++;
    if (pc !== 16'h0040) begin
      errors++;
      $display("FAIL branch_abs pc=%h expected 0040", pc);
    end
    imm = 16'hFFFF;
    tick();
    pc_sel = 0;
    tick();
    pc_write = 0;
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL pc_wrap pc=%h expected 0000", pc);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    pc_write = 1; pc_sel = 1; br_sel = 1; imm = 16'h0077;
    tick();
    pc_rst = 1; imm = 16'h0020;
    tick();
    pc_rst = 0; pc_write = 0;
    checks++;
    if (pc !== 16'h0000) begin
      errors++;
      $display("FAIL pc_rst_priority pc=%h expected 0000", pc);
    end
    ir_load = 1;
    tick();
    pc_write = 1; pc_sel = 0;
    repeat (3) tick();
    checks++;
    if (imem_addr !== 16'h0000 || imem_req !== 1'b1 || pc !== 16'h0003) begin
      errors++;
      $display("FAIL load_in_wait addr=%h req=%b pc=%h expected 0000 1 0003",
               imem_addr, imem_req, pc);
    end
    ir_load = 0; pc_write = 0;
    imem_ack = 1; imem_rdata = 32'hCAFE_0001;
    tick();
    imem_ack = 0;
    tick();
    checks++;
    if (imem_req !== 1'b0 || fetch_busy !== 1'b0 || ir !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL no_second_req req=%b busy=%b ir=%h expected 0 0 cafe0001",
               imem_req, fetch_busy, ir);
    end
  endtask

  task automatic test_timeout();
    idle_inputs();
    ir_load = 1;
    tick();
    ir_load = 0;
`ifdef SISC_FETCH_TIMEOUT_EN
    repeat (TMO - 1) tick();
    checks++;
    if (imem_req !== 1'b1 || ir_valid !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early req=%b vld=%b err=%b expected 1 0 0",
               imem_req, ir_valid, fetch_err);
    end
    tick();
    checks++;
    if (ir !== 32'h0 || ir_valid !== 1'b1 || fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire ir=%h vld=%b err=%b req=%b expected 0 1 1 0",
               ir, ir_valid, fetch_err, imem_req);
    end
    tick();
    ir_load = 1;
    tick();
    ir_load = 0;
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 0;
    checks++;
    if (ir !== 32'h1234_5678 || ir_valid !== 1'b1 || fetch_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover ir=%h vld=%b err=%b expected 12345678 1 1",
               ir, ir_valid, fetch_err);
    end
`else
    repeat (100) tick();
    checks++;
    if (fetch_busy !== 1'b1 || imem_req !== 1'b1 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout busy=%b req=%b err=%b expected 1 1 0",
               fetch_busy, imem_req, fetch_err);
    end
`endif
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      pc_rst = ($urandom_range(0, 15) == 0);
      pc_write = $urandom_range(0, 1);
      pc_sel = $urandom_range(0, 1);
      br_sel = $urandom_range(0, 1);
      ir_load = $urandom_range(0, 1);
      imm = 16'($urandom);
      imem_ack = ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom;
      tick();
      checks++;
      if (pc !== 16'(m_pc) || ir !== m_ir || imem_req !== m_req ||
          imem_addr !== 16'(m_addr) || ir_valid !== m_valid ||
          fetch_busy !== m_busy || fetch_err !== m_err) begin
        errors++;
        $display("FAIL random_%0d pc=%h/%h ir=%h/%h req=%b/%b addr=%h/%h vld=%b/%b busy=%b/%b err=%b/%b (got/expected)",
                 i, pc, 16'(m_pc), ir, m_ir, imem_req, m_req, imem_addr,
                 16'(m_addr), ir_valid, m_valid, fetch_busy, m_busy,
                 fetch_err, m_err);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_pc = 0; m_addr = 0; m_waited = 0; m_ir = 0;
    m_req = 0; m_busy = 0; m_err = 0; m_valid = 0; m_in_err = 0;
    #1;
    test_reset();
    test_fetch();
    test_branch();
    test_priority();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
